// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Performs request-to-send, shifts start/data/parity/stop out on device
// clock falls, checks the device ACK bit, and drives the open-drain bus
// only through pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       key_clk_i,
  input  logic       key_data_i,
  output logic       key_clk_oe,
  output logic       key_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [INH_W-1:0] inh_cnt, inh_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [3:0]       bit_cnt, bit_n;
  logic [7:0]       byte_q, byte_n;
  logic             par_q, par_n;
  logic             ack_q, ack_n;
  logic             clk_oe_q, clk_oe_n;
  logic             data_oe_q, data_oe_n;

  logic clk_r0, clk_r1;
  logic data_r0, data_r1;
  logic fall;
  logic tmo_active;

  // Two-flop synchronizers for both bus lines; idle bus reads high.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      clk_r0  <= 1'b1;
      clk_r1  <= 1'b1;
      data_r0 <= 1'b1;
      data_r1 <= 1'b1;
    end else begin
      clk_r0  <= key_clk_i;
      clk_r1  <= clk_r0;
      data_r0 <= key_data_i;
      data_r1 <= data_r0;
    end
  end

  assign fall = clk_r1 & ~clk_r0;

  // State, counters, latched byte and registered pull-low enables.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state     <= state_n;
      inh_cnt   <= inh_n;
      tmo_cnt   <= tmo_n;
      bit_cnt   <= bit_n;
      byte_q    <= byte_n;
      par_q     <= par_n;
      ack_q     <= ack_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
    end
  end

  assign tmo_active = (state == S_REQ) || (state == S_SEND) ||
                      (state == S_ACK) || (state == S_WAIT_IDLE);

  // Next-state logic. The line enables are computed from the next state and
  // next inhibit count and then registered, so the start bit appears in the
  // last inhibit cycle without a combinational path onto the pads.
  always_comb begin
    state_n   = state;
    inh_n     = inh_cnt;
    tmo_n     = tmo_cnt;
    bit_n     = bit_cnt;
    byte_n    = byte_q;
    par_n     = par_q;
    ack_n     = ack_q;
    data_oe_n = data_oe_q;
    tx_done   = 1'b0;
    tx_err    = 1'b0;

    if (tmo_active) begin
      tmo_n = tmo_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (tx_valid) begin
          state_n   = S_INHIBIT;
          inh_n     = '0;
          bit_n     = '0;
          byte_n    = tx_data;
          par_n     = ~^tx_data;
          data_oe_n = (INH_LAST == '0);
        end
      end

      S_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_n   = S_REQ;
          tmo_n     = '0;
          data_oe_n = 1'b1;
        end else begin
          inh_n     = inh_cnt + 1'b1;
          data_oe_n = (inh_n == INH_LAST);
        end
      end

      S_REQ: begin
        state_n = S_SEND;
      end

      S_SEND: begin
        if (fall) begin
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            data_oe_n = ~byte_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_n = ~par_q;
          end else begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (fall) begin
          ack_n   = ~data_r1;
          state_n = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_r1 && data_r1) begin
          tx_done = ack_q;
          tx_err  = ~ack_q;
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n   = S_IDLE;
        data_oe_n = 1'b0;
      end
    endcase

    // Timeout overrides any transition in the bus-active states.
    if (tmo_active && (tmo_cnt == TMO_MAX)) begin
      state_n   = S_IDLE;
      data_oe_n = 1'b0;
      tx_done   = 1'b0;
      tx_err    = 1'b1;
    end

    clk_oe_n = (state_n == S_INHIBIT);
  end

  assign key_clk_oe  = clk_oe_q;
  assign key_data_oe = data_oe_q;
  assign tx_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// and a frame scoreboard.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 100;
  localparam int unsigned TMO  = 5000;
  localparam int unsigned HALF = 40;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       key_clk_i;
  logic       key_data_i;
  logic       key_clk_oe;
  logic       key_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  logic dev_clk;
  logic dev_data;

  // Open-drain bus: either side can pull low, pull-up otherwise.
  assign key_clk_i  = dev_clk  & ~key_clk_oe;
  assign key_data_i = dev_data & ~key_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .key_clk_i   (key_clk_i),
    .key_data_i  (key_data_i),
    .key_clk_oe  (key_clk_oe),
    .key_data_oe (key_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  int   last_inh_len = 0;
  logic inh_d_last = 1'b0;
  logic inh_d_prev = 1'b0;
  int   dev_falls = 0;
  bit   dev_clocking = 1'b1;
  bit   dev_ack = 1'b1;
  int   inh_len;

  // Pulse counters for tx_done / tx_err.
  always @(negedge clk_in) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- device model ----------------
  task automatic dev_half(output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk_in);
      if (!rst) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic dev_frame();
    logic [10:0] bits;
    bit ab;
    bits = '0;
    bits[0] = key_data_i;
    dev_falls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (!rst) return;
    end
    for (int n = 1; n <= 10; n++) begin
      dev_clk = 1'b0;
      dev_falls = n;
      dev_half(ab);
      if (ab) begin dev_clk = 1'b1; dev_data = 1'b1; return; end
      bits[n] = key_data_i;
      dev_clk = 1'b1;
      dev_half(ab);
      if (ab) begin dev_clk = 1'b1; dev_data = 1'b1; return; end
    end
    if (dev_ack) dev_data = 1'b0;
    dev_half(ab);
    if (ab) begin dev_clk = 1'b1; dev_data = 1'b1; return; end
    dev_clk = 1'b0;
    dev_falls = 11;
    dev_half(ab);
    dev_clk = 1'b1;
    dev_data = 1'b1;
    if (!ab) got_q.push_back(bits);
  endtask

  // Device: measures the inhibit window, then clocks a frame in on release.
  initial begin
    dev_clk = 1'b1;
    dev_data = 1'b1;
    forever begin
      @(negedge clk_in);
      if (key_clk_oe === 1'b1) begin
        inh_len = 0;
        inh_d_prev = 1'b0;
        inh_d_last = 1'b0;
        while (key_clk_oe === 1'b1) begin
          inh_len++;
          inh_d_prev = inh_d_last;
          inh_d_last = key_data_oe;
          @(negedge clk_in);
        end
        last_inh_len = inh_len;
        if (dev_clocking && rst) dev_frame();
      end
    end
  end

  // ---------------- host-side stimulus ----------------
  task automatic send(input logic [7:0] b, input bit expect_frame);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 20000) begin
      @(negedge clk_in);
      w++;
    end
    chk("ready_before_send", tx_ready, 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("clk_oe_after_accept", key_clk_oe, 1);
    if (expect_frame) exp_q.push_back(frame_of(b));
  endtask

  task automatic wait_end(input string tag, output bit got_done, output bit got_err);
    int cyc;
    cyc = 0;
    while (tx_done !== 1'b1 && tx_err !== 1'b1 && cyc < 8000) begin
      @(negedge clk_in);
      cyc++;
    end
    got_done = (tx_done === 1'b1);
    got_err  = (tx_err === 1'b1);
    chk({tag, "_completed"}, {31'd0, got_done | got_err}, 1);
  endtask

  task automatic after_end(input string tag);
    @(negedge clk_in);
    chk({tag, "_ready_after"}, tx_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_pulse_width"}, {30'd0, tx_done, tx_err}, 0);
  endtask

  task automatic check_frame(input string tag);
    logic [10:0] e;
    logic [10:0] g;
    chk({tag, "_frame_avail"}, {31'd0, (got_q.size() > 0) && (exp_q.size() > 0)}, 1);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_frame"}, {21'd0, g}, {21'd0, e});
    end
  endtask

  initial begin
    bit gd, ge;
    int d0, e0, w, cyc;

    rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (5) @(negedge clk_in);
    chk("rst_clk_oe", key_clk_oe, 0);
    chk("rst_data_oe", key_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_ready", tx_ready, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk_in);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 1'b1);
    wait_end("ed", gd, ge);
    chk("ed_done", gd, 1);
    chk("ed_err", ge, 0);
    after_end("ed");
    check_frame("ed");
    chk("ed_inhibit_len", last_inh_len, INH);
    chk("ed_start_last_inhibit", inh_d_last, 1);
    chk("ed_no_start_early", inh_d_prev, 0);
    @(negedge clk_in);
    chk("ed_done_count", done_cnt - d0, 1);
    chk("ed_err_count", err_cnt - e0, 0);

    // 0x01 then 0x00 back-to-back; tx_valid held high while busy
    d0 = done_cnt; e0 = err_cnt;
    send(8'h01, 1'b1);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    exp_q.push_back(frame_of(8'h00));
    repeat (10) @(negedge clk_in);
    chk("b2b_held_valid_ignored", tx_ready, 0);
    wait_end("b2b1", gd, ge);
    chk("b2b1_done", gd, 1);
    @(negedge clk_in);
    chk("b2b_ready_cycle_after_done", tx_ready, 1);
    @(negedge clk_in);
    tx_valid = 1'b0;
    chk("b2b_second_accept_busy", busy, 1);
    chk("b2b_second_accept_clk_oe", key_clk_oe, 1);
    check_frame("b2b1");
    wait_end("b2b2", gd, ge);
    chk("b2b2_done", gd, 1);
    after_end("b2b2");
    check_frame("b2b2");
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_err_count", err_cnt - e0, 0);

    // 0xFF without ACK
    dev_ack = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF, 1'b1);
    wait_end("nack", gd, ge);
    chk("nack_done", gd, 0);
    chk("nack_err", ge, 1);
    chk("nack_lines_idle", {30'd0, key_clk_i, key_data_i}, 3);
    after_end("nack");
    check_frame("nack");
    chk("nack_done_count", done_cnt - d0, 0);
    chk("nack_err_count", err_cnt - e0, 1);
    dev_ack = 1'b1;

    // 0xF4, device never clocks
    dev_clocking = 1'b0;
    send(8'hF4, 1'b0);
    w = 0;
    while (key_clk_oe === 1'b1 && w < 500) begin
      @(negedge clk_in);
      w++;
    end
    chk("tmo_req_entered", key_clk_oe, 0);
    cyc = 0;
    while (tx_err !== 1'b1 && tx_done !== 1'b1 && cyc < 6000) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_err", tx_err, 1);
    chk("tmo_no_done", tx_done, 0);
    @(negedge clk_in);
    chk("tmo_oe_released", {30'd0, key_clk_oe, key_data_oe}, 0);
    chk("tmo_idle", tx_ready, 1);
    dev_clocking = 1'b1;

    // Reset during SEND while the data line is pulled low (d[4] of 0xED)
    send(8'hED, 1'b0);
    w = 0;
    while (dev_falls != 5 && w < 3000) begin
      @(negedge clk_in);
      w++;
    end
    chk("rstmid_reached_bit4", dev_falls, 5);
    repeat (10) @(negedge clk_in);
    chk("rstmid_data_low_before", key_data_oe, 1);
    rst = 1'b0;
    #1;
    chk("rstmid_oe_released", {30'd0, key_clk_oe, key_data_oe}, 0);
    chk("rstmid_ready", tx_ready, 1);
    repeat (5) @(negedge clk_in);
    rst = 1'b1;
    repeat (100) @(negedge clk_in);
    chk("rstmid_no_stray_frame", got_q.size(), 0);
    d0 = done_cnt;
    send(8'hED, 1'b1);
    wait_end("rstmid_ed", gd, ge);
    chk("rstmid_ed_done", gd, 1);
    after_end("rstmid_ed");
    check_frame("rstmid_ed");

    // 0xAA pulsed while a 0xC3 frame is in flight
    d0 = done_cnt; e0 = err_cnt;
    send(8'hC3, 1'b1);
    w = 0;
    while (dev_falls != 3 && w < 3000) begin
      @(negedge clk_in);
      w++;
    end
    chk("ign_reached_bit", dev_falls, 3);
    chk("ign_not_ready", tx_ready, 0);
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    wait_end("ign", gd, ge);
    chk("ign_done", gd, 1);
    after_end("ign");
    check_frame("ign");
    repeat (200) @(negedge clk_in);
    chk("ign_no_second_accept", busy, 0);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_err_count", err_cnt - e0, 0);
    chk("ign_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard on the same two-wire open-drain bus that the keyboard receiver listens on. It implements the host request-to-send sequence, clocks the 11-bit frame out on device-generated clock edges, and checks the device ACK bit. It drives the lines only through pull-low enables. While `busy` is high, the keyboard receiver's output is don't-care.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 10000: clk_in cycles that key_clk is held low for request-to-send (≥100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: clk_in cycles allowed from clock release to completion (20 ms).

Ports (reset rst, asynchronous, active-low; clock clk_in):
- `clk_in` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `tx_data` input 8: command byte. Sampled on accept.
- `tx_valid` input 1: request to send tx_data.
- `tx_ready` output 1: high only in IDLE. Accept occurs when tx_valid && tx_ready.
- `key_clk_i` input 1: PS/2 clock line, read back.
- `key_data_i` input 1: PS/2 data line, read back.
- `key_clk_oe` output 1: 1 pulls the clock line low, 0 releases it (pull-up).
- `key_data_oe` output 1: 1 pulls the data line low, 0 releases it.
- `busy` output 1: high in every state except IDLE.
- `tx_done` output 1: one-cycle pulse on successful ACKed transfer.
- `tx_err` output 1: one-cycle pulse on missing ACK or timeout.

## Operation
- key_clk_i and key_data_i each pass through a 2-flop synchronizer, reset to 1. `fall = r1 & ~r0`.
- Data bit driven = ~key_data_oe. Frame: start 0, d[0..7] LSB first, odd parity (~^d), stop 1, device ACK 0.
- States:
  - IDLE: both oe=0, tx_ready=1. On accept: latch byte, compute parity, load a bit counter with 0, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0. Counter runs to INHIBIT_CYCLES. Then data_oe=1 (start bit) for that cycle, with clk_oe still 1; go to REQ.
  - REQ: clk_oe=0, data_oe=1. Start timeout counter. Go to SEND.
  - SEND: on fall number n (n=1..8), data_oe=~d[n-1]. On fall 9, data_oe=~parity. On fall 10, data_oe=0 (stop). Go to ACK.
  - ACK: on fall 11, sample synchronized data. 0 → ack_ok, else ack_bad. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines read 1. Then pulse tx_done if ack_ok, or tx_err if ack_bad. Go to IDLE.
- Timeout: in REQ, SEND, ACK or WAIT_IDLE, when the timeout counter reaches TIMEOUT_CYCLES: release both lines, pulse tx_err, go to IDLE.
- tx_valid while busy is ignored, not queued. tx_data changes after accept have no effect.
- Falls seen in IDLE or INHIBIT are ignored.

## Timing
- Reset values: key_clk_oe=0, key_data_oe=0, busy=0, tx_done=0, tx_err=0, tx_ready=1. All counters and state return to IDLE.
- Asserting rst mid-frame releases both lines immediately (asynchronous).
- Accept at edge T: busy=1 and clk_oe=1 from T+1. clk_oe stays 1 for exactly INHIBIT_CYCLES cycles. data_oe rises in the last of those cycles.
- Data updates are registered one cycle after the `fall` detection cycle, which is 3 clk_in cycles after the pad edge. This is well inside the device's ~40 µs clock-low window.
- tx_done and tx_err are mutually exclusive and last exactly one cycle. They coincide with the return to IDLE: tx_ready=1 and busy=0 in the following cycle.
- A new accept is possible the cycle after tx_done or tx_err.

## Test plan
Bench settings: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, plus a device model that clocks at a 40-clk_in half-period.

- Send 0xED with device ACK → line bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1. Single tx_done, no tx_err. clk_oe low for exactly 100 cycles.
- Send 0x01, then 0x00, back-to-back with ACK → parity 0, then parity 1. Second accept occurs the cycle after the first tx_done.
- Send 0xFF, device leaves data high at the 11th clock → tx_err pulse after both lines idle, no tx_done.
- Send 0xF4, device never clocks → tx_err exactly 5000 cycles after REQ entry. Both oe=0 afterwards.
- rst low during SEND at bit 4 → both oe=0 immediately, tx_ready=1. A following 0xED sends cleanly.
- tx_valid pulsed with 0xAA while busy, mid-frame → ignored. The frame in flight is unchanged and only one tx_done occurs.
